// File: rtl/sw_input_ctrl.sv
// sw_input_ctrl: 8-bit switch input port on AHB-Lite with edge-pending interrupt.
// Define SW_DEBOUNCE_EN to add the tick prescaler and per-bit debounce counters.
module sw_input_ctrl #(
    parameter logic [15:0] DIV_RST    = 16'd49999,
    parameter int          DB_SAMPLES = 4
) (
    input  logic        clk,
    input  logic        RSTn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    input  logic [7:0]  SW,
    output logic        IRQ
);
    logic [7:0]  sync1_q, sync1_d, sync2_q, sync2_d, stat, stat_prev_q, stat_prev_d;
    logic [7:0]  ien_q, ien_d, pend_q, pend_d, edge_q, edge_d;
    logic        irq_q, irq_d, act_q, act_d, wr_q, wr_d, wr_en;
    logic [1:0]  addr_q, addr_d;
    logic [15:0] div_rd;
    logic        unused_ok;

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign IRQ       = irq_q;
    assign wr_en     = act_q & wr_q;
    assign unused_ok = ^{HSIZE, HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:24]};

    // Hardware set is OR-ed in after the W1C mask so it wins on a collision
    always_comb begin
        sync1_d     = SW;
        sync2_d     = sync1_q;
        stat_prev_d = stat;
        act_d       = HSEL & HTRANS[1] & HREADY;
        wr_d        = HWRITE;
        addr_d      = HADDR[3:2];
        ien_d       = (wr_en && addr_q == 2'd1) ? HWDATA[7:0] : ien_q;
        edge_d      = (wr_en && addr_q == 2'd3) ? HWDATA[23:16] : edge_q;
        pend_d      = (pend_q & ~((wr_en && addr_q == 2'd2) ? HWDATA[7:0] : 8'h00))
                    | ((stat ^ stat_prev_q) & (stat | ~edge_q));
        irq_d       = |(pend_q & ien_q);
        HRDATA      = (addr_q == 2'd0) ? {24'h0, stat}  :
                      (addr_q == 2'd1) ? {24'h0, ien_q} :
                      (addr_q == 2'd2) ? {24'h0, pend_q} : {8'h0, edge_q, div_rd};
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            stat_prev_q <= '0;
            act_q       <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            ien_q       <= '0;
            edge_q      <= '0;
            pend_q      <= '0;
            irq_q       <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            stat_prev_q <= stat_prev_d;
            act_q       <= act_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            ien_q       <= ien_d;
            edge_q      <= edge_d;
            pend_q      <= pend_d;
            irq_q       <= irq_d;
        end
    end

`ifdef SW_DEBOUNCE_EN
    logic [15:0]     div_q, div_d, pre_q, pre_d;
    logic [7:0]      stat_q, stat_d;
    logic [7:0][3:0] db_q, db_d;
    logic            tick, cfg_wr;

    assign cfg_wr = wr_en && addr_q == 2'd3;
    assign tick   = pre_q == div_q;
    assign stat   = stat_q;
    assign div_rd = div_q;

    always_comb begin
        div_d  = cfg_wr ? HWDATA[15:0] : div_q;
        pre_d  = (cfg_wr || tick) ? 16'h0 : pre_q + 16'h1;
        stat_d = stat_q;
        db_d   = db_q;
        for (int i = 0; i < 8; i++) begin
            if (tick) begin
                db_d[i] = (sync2_q[i] != stat_q[i]) ? db_q[i] + 4'h1 : 4'h0;
                if (db_d[i] == 4'(DB_SAMPLES)) begin
                    stat_d[i] = sync2_q[i];
                    db_d[i]   = 4'h0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            div_q  <= DIV_RST;
            pre_q  <= '0;
            stat_q <= '0;
            db_q   <= '0;
        end else begin
            div_q  <= div_d;
            pre_q  <= pre_d;
            stat_q <= stat_d;
            db_q   <= db_d;
        end
    end
`else
    logic unused_db;

    assign stat      = sync2_q;
    assign div_rd    = 16'h0;
    assign unused_db = ^{HWDATA[15:8], DIV_RST, 32'(DB_SAMPLES)};
`endif
endmodule

// File: tb/tb_sw_input_ctrl.sv
// tb_sw_input_ctrl: directed AHB-Lite and switch stimulus with immediate-assertion checks.
module tb_sw_input_ctrl;
`ifdef SW_DEBOUNCE_EN
    localparam int          LAT     = 6;
    localparam logic [31:0] CFG_RST = 32'h0000C34F;
`else
    localparam int          LAT     = 2;
    localparam logic [31:0] CFG_RST = 32'h0;
`endif
    logic        clk = 0, RSTn = 0, HSEL = 0, HWRITE = 0, HREADY = 1;
    logic [31:0] HADDR = 0, HWDATA = 0, HRDATA;
    logic [1:0]  HTRANS = 0;
    logic [2:0]  HSIZE = 3'd2;
    logic [7:0]  SW = 0;
    logic        HREADYOUT, HRESP, IRQ;
    int          passed = 0, failed = 0, total = 0;

    sw_input_ctrl dut (
        .clk(clk), .RSTn(RSTn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .SW(SW), .IRQ(IRQ)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // All bus tasks start and end 1 time unit after a rising edge
    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = a;
        @(posedge clk); #1;
        HSEL = 0; HTRANS = 2'b00;
        d = HRDATA;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = a;
        @(posedge clk); #1;
        HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HWDATA = d;
        @(posedge clk); #1;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] e);
        logic [31:0] d;
        bus_rd(a, d);
        check(tag, d, e);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 RSTn = 1;
        check("rst_irq", {31'h0, IRQ}, 32'h0);
        check("hreadyout", {31'h0, HREADYOUT}, 32'h1);
        check("hresp", {31'h0, HRESP}, 32'h0);
        rd_chk("rst_data", 32'h0, 32'h0);
        rd_chk("rst_cfg", 32'hC, CFG_RST);
        rd_chk("rst_pend", 32'h8, 32'h0);
        bus_wr(32'hC, 32'h0);
        rd_chk("cfg_div0", 32'hC, 32'h0);
        bus_wr(32'h4, 32'hFFFF_FF01);
        rd_chk("ien_rw", 32'h4, 32'h1);
        bus_wr(32'h0, 32'hFF);
        rd_chk("data_ro", 32'h0, 32'h0);

        SW = 8'hAA;
        cyc(LAT - 2);
        rd_chk("data_early", 32'h0, 32'h0);
        rd_chk("data_aa", 32'h0, 32'hAA);
        rd_chk("pend_aa", 32'h8, 32'hAA);
        check("irq_masked", {31'h0, IRQ}, 32'h0);
        bus_wr(32'h8, 32'hFF);
        rd_chk("pend_w1c_all", 32'h8, 32'h0);

        SW = 8'hAB;
        cyc(LAT);
        check("irq_pre0", {31'h0, IRQ}, 32'h0);
        cyc(1);
        check("irq_pre1", {31'h0, IRQ}, 32'h0);
        cyc(1);
        check("irq_set", {31'h0, IRQ}, 32'h1);
        bus_wr(32'h8, 32'h1);
        check("irq_hold", {31'h0, IRQ}, 32'h1);
        cyc(1);
        check("irq_clr", {31'h0, IRQ}, 32'h0);
        rd_chk("pend_clr0", 32'h8, 32'h0);

        SW = 8'hA9;
        cyc(LAT - 1);
        bus_wr(32'h8, 32'h2);
        rd_chk("pend_set_prio", 32'h8, 32'h2);
        bus_wr(32'h8, 32'hFF);

        bus_wr(32'hC, 32'h00FF_0000);
        rd_chk("cfg_edge", 32'hC, 32'h00FF_0000);
        SW = 8'h00;
        cyc(LAT + 2);
        rd_chk("data_fall", 32'h0, 32'h0);
        rd_chk("pend_fall_filt", 32'h8, 32'h0);
        SW = 8'h0F;
        cyc(LAT + 2);
        rd_chk("pend_rise", 32'h8, 32'h0F);
        rd_chk("data_0f", 32'h0, 32'h0F);
        check("irq_rise", {31'h0, IRQ}, 32'h1);
        bus_wr(32'h4, 32'h0);
        rd_chk("ien_off", 32'h4, 32'h0);
        cyc(1);
        check("irq_ien_off", {31'h0, IRQ}, 32'h0);

`ifdef SW_DEBOUNCE_EN
        bus_wr(32'h8, 32'hFF);
        bus_wr(32'hC, 32'h0);
        SW = 8'h1F;
        cyc(3);
        SW = 8'h0F;
        cyc(10);
        rd_chk("glitch_data", 32'h0, 32'h0F);
        rd_chk("glitch_pend", 32'h8, 32'h0);
`endif

        bus_wr(32'h4, 32'h1);
        RSTn = 0;
        cyc(2);
        check("rst_async_irq", {31'h0, IRQ}, 32'h0);
        RSTn = 1;
        bus_wr(32'hC, 32'h0);
        cyc(LAT + 4);
        rd_chk("rst_hi_pend", 32'h8, 32'h0F);
        rd_chk("rst_hi_data", 32'h0, 32'h0F);
        rd_chk("rst_ien", 32'h4, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
